// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared types and constant helpers for the fifo_sync_thr FIFO.
//   - fifo_op_e   : decoded operation for one cycle (from accepted push/pull)
//   - ptr_width   : bits needed to index DEPTH entries
//   - count_width : bits needed to hold an occupancy of 0..DEPTH
//   - next_ptr    : wrapping increment for any depth (compare-and-reset)
//   - decode_op   : maps accepted push/pull to fifo_op_e
// -----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PULL = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Wrap at DEPTH-1 explicitly so non-power-of-two depths work.
    function automatic int unsigned next_ptr(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

    function automatic fifo_op_e decode_op(input logic push_ok, input logic pull_ok);
        return fifo_op_e'({push_ok, pull_ok});
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// -----------------------------------------------------------------------------
// fifo_wrap_ptr
//   Wrapping pointer register, 0..DEPTH-1. Used for both head and tail.
// Ports
//   clk    in   1    clock
//   rst_n  in   1    asynchronous active-low reset (ptr -> 0)
//   clr    in   1    synchronous clear (ptr -> 0), has priority over inc
//   inc    in   1    advance by one, wrapping DEPTH-1 -> 0
//   ptr    out  PW   current pointer value
// -----------------------------------------------------------------------------
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 32,
    localparam int PW = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= PW'(next_ptr(32'(ptr), DEPTH));
        end
    end

endmodule

// File: rtl/fifo_sync_thr.sv
// -----------------------------------------------------------------------------
// fifo_sync_thr
//   Single-clock show-ahead FIFO of any depth >= 2 with occupancy count,
//   almost-full/almost-empty thresholds, sticky overflow/underflow flags,
//   synchronous flush and optional per-entry even parity.
//
//   Build option: define FIFO_PARITY_EN to store a parity bit per entry and
//   drive parity_err on pops; without it parity_err is constant 0.
//
// Parameters
//   WIDTH      data bits per entry
//   DEPTH      number of entries (any value >= 2)
//   AFULL_TH   almost_full  when count >= AFULL_TH
//   AEMPTY_TH  almost_empty when count <= AEMPTY_TH
// Ports
//   clk           in   1      clock
//   rst_n         in   1      asynchronous active-low reset
//   push          in   1      write request (accepted when !full)
//   datain        in   WIDTH  write data
//   pull          in   1      read request (accepted when !empty)
//   dataout       out  WIDTH  head entry, 0 while empty
//   flush         in   1      synchronous clear of contents
//   err_clr       in   1      clears overflow/underflow
//   full, empty, almost_full, almost_empty   out  1  status from count
//   count         out  CW     occupancy
//   overflow      out  1      sticky: push while full
//   underflow     out  1      sticky: pull while empty
//   parity_err    out  1      stored parity mismatch on an accepted pull
// -----------------------------------------------------------------------------
module fifo_sync_thr
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int AFULL_TH  = 28,
    parameter int AEMPTY_TH = 4,
    localparam int CW = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] datain,
    input  logic             pull,
    output logic [WIDTH-1:0] dataout,
    input  logic             flush,
    input  logic             err_clr,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    output logic             parity_err
);

    localparam int PW = ptr_width(DEPTH);
`ifdef FIFO_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [SW-1:0] mem [DEPTH];
    logic [SW-1:0] wr_word;
    logic [SW-1:0] head_word;
    logic          push_ok;
    logic          pull_ok;
    logic          do_push;
    logic          do_pull;
    fifo_op_e      op;

    // Acceptance looks only at registered state: a same-cycle pull never
    // makes room for a push, and a same-cycle push never feeds a pull.
    assign push_ok = push && !full;
    assign pull_ok = pull && !empty;

    // flush overrides both operations for this edge.
    assign op      = flush ? OP_IDLE : decode_op(push_ok, pull_ok);
    assign do_push = (op == OP_PUSH) || (op == OP_BOTH);
    assign do_pull = (op == OP_PULL) || (op == OP_BOTH);

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (do_push),
        .ptr   (head)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (do_pull),
        .ptr   (tail)
    );

`ifdef FIFO_PARITY_EN
    // Stored bit makes the whole entry even parity.
    assign wr_word = {^datain, datain};
`else
    assign wr_word = datain;
`endif

    // NOTE: storage has no reset; validity is tracked entirely by head/tail/
    // count, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[head] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case (op)
                OP_PUSH: count <= count + CW'(1);
                OP_PULL: count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags: setting beats err_clr; flush suppresses setting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full && !flush) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (pull && empty && !flush) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AFULL_TH));
    assign almost_empty = (count <= CW'(AEMPTY_TH));

    assign head_word = mem[tail];

    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        dataout    = '0;
        parity_err = 1'b0;
        if (!empty) begin
            dataout = head_word[WIDTH-1:0];
        end
`ifdef FIFO_PARITY_EN
        if (do_pull) begin
            parity_err = head_word[WIDTH] ^ (^head_word[WIDTH-1:0]);
        end
`endif
    end

endmodule

// File: tb/tb_fifo_sync_thr.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_thr
//   Scoreboard bench for fifo_sync_thr: a DEPTH=32 instance (defaults) and a
//   DEPTH=5, WIDTH=8 instance for wrap streaming. Expected data is queued on
//   accepted pushes and compared on accepted pulls.
// -----------------------------------------------------------------------------
module tb_fifo_sync_thr;

    localparam logic [11:0] RESET_STATUS = 12'b0101_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0, pull = 1'b0, flush = 1'b0, err_clr = 1'b0;
    logic [31:0] datain = '0;
    logic [31:0] dataout;
    logic        full, empty, almost_full, almost_empty;
    logic [5:0]  count;
    logic        overflow, underflow, parity_err;

    logic        push5 = 1'b0, pull5 = 1'b0;
    logic [7:0]  datain5 = '0;
    logic [7:0]  dataout5;
    logic        full5, empty5, afull5, aempty5, ovf5, unf5, perr5;
    logic [2:0]  count5;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    int          m_count = 0;
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;
    int          par_hits = 0;

    always #5 clk = ~clk;

    fifo_sync_thr dut (
        .clk(clk), .rst_n(rst_n), .push(push), .datain(datain), .pull(pull),
        .dataout(dataout), .flush(flush), .err_clr(err_clr), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .parity_err(parity_err)
    );

    fifo_sync_thr #(.WIDTH(8), .DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .push(push5), .datain(datain5), .pull(pull5),
        .dataout(dataout5), .flush(1'b0), .err_clr(1'b0), .full(full5),
        .empty(empty5), .almost_full(afull5), .almost_empty(aempty5),
        .count(count5), .overflow(ovf5), .underflow(unf5), .parity_err(perr5)
    );

    function automatic logic [11:0] obs_status();
        return {full, empty, almost_full, almost_empty, overflow, underflow, count};
    endfunction

    function automatic logic [11:0] exp_status();
        return {m_count == 32, m_count == 0, m_count >= 28, m_count <= 4,
                m_ovf, m_unf, 6'(m_count)};
    endfunction

    // One clock of stimulus on the DEPTH=32 instance; updates the model and
    // compares dataout against the scoreboard on every accepted pull.
    task automatic step(input bit p, input logic [31:0] d, input bit q,
                        input bit f = 1'b0, input bit e = 1'b0);
        bit          pu_ok, pl_ok;
        logic [31:0] exp_d;
        @(negedge clk);
        push = p; datain = d; pull = q; flush = f; err_clr = e;
        #1;
        pu_ok = p && (m_count < 32) && !f;
        pl_ok = q && (m_count > 0) && !f;
        if (parity_err === 1'b1) par_hits++;
        if (pl_ok) begin
            exp_d = exp_q.pop_front();
            tests_run++;
            if (dataout !== exp_d) begin
                tests_failed++;
                $display("FAIL pop_data: got %h expected %h", dataout, exp_d);
            end
        end
        if (!f && p && m_count == 32) m_ovf = 1'b1;
        else if (e) m_ovf = 1'b0;
        if (!f && q && m_count == 0) m_unf = 1'b1;
        else if (e) m_unf = 1'b0;
        if (f) begin
            exp_q.delete();
            m_count = 0;
        end else begin
            if (pu_ok) exp_q.push_back(d);
            m_count += int'(pu_ok) - int'(pl_ok);
        end
        @(posedge clk);
        #1;
        push = 1'b0; pull = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (obs_status() !== RESET_STATUS) begin
            tests_failed++;
            $display("FAIL reset_status: got %b expected %b", obs_status(), RESET_STATUS);
        end
        tests_run++;
        if (dataout !== 32'h0 || parity_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h/%b expected 0/0", dataout, parity_err);
        end
        tests_run++;
        if (empty5 !== 1'b1 || count5 !== 3'd0 || dataout5 !== 8'h0) begin
            tests_failed++;
            $display("FAIL reset_dut5: got %b/%0d/%h expected 1/0/00", empty5, count5, dataout5);
        end
    endtask

    task automatic test_fill_drain();
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, 32'(k), 1'b0);
            tests_run++;
            if (almost_full !== (k >= 28)) begin
                tests_failed++;
                $display("FAIL almost_full@%0d: got %b expected %b", k, almost_full, k >= 28);
            end
        end
        tests_run++;
        if (full !== 1'b1 || count !== 6'd32) begin
            tests_failed++;
            $display("FAIL fill_full: got %b/%0d expected 1/32", full, count);
        end
        step(1'b1, 32'h21, 1'b0);
        tests_run++;
        if (obs_status() !== exp_status() || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL push_33: got %b expected %b", obs_status(), exp_status());
        end
        for (int k = 0; k < 32; k++) step(1'b0, '0, 1'b1);
        tests_run++;
        if (obs_status() !== exp_status() || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL drained: got %b expected %b", obs_status(), exp_status());
        end
    endtask

    task automatic test_both_ops();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 32; k++) step(1'b1, 32'h100 + 32'(k), 1'b0);
        step(1'b1, 32'hDEAD, 1'b1);
        tests_run++;
        if (obs_status() !== exp_status() || count !== 6'd31 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL both_full: got %b expected %b", obs_status(), exp_status());
        end
        for (int k = 0; k < 31; k++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h55, 1'b1);
        tests_run++;
        if (obs_status() !== exp_status() || count !== 6'd1 || underflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL both_empty: got %b expected %b", obs_status(), exp_status());
        end
        tests_run++;
        if (dataout !== 32'h55) begin
            tests_failed++;
            $display("FAIL both_empty_data: got %h expected 00000055", dataout);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        for (int k = 0; k < 10; k++) step(1'b1, 32'h200 + 32'(k), 1'b0);
        step(1'b1, 32'h99, 1'b0, 1'b1);
        tests_run++;
        if (obs_status() !== exp_status() || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush: got %b expected %b", obs_status(), exp_status());
        end
        step(1'b1, 32'hAB, 1'b0);
        tests_run++;
        if (dataout !== 32'hAB || count !== 6'd1) begin
            tests_failed++;
            $display("FAIL after_flush: got %h/%0d expected 000000ab/1", dataout, count);
        end
        step(1'b0, '0, 1'b1);
    endtask

    task automatic test_sticky();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 32; k++) step(1'b1, 32'h300 + 32'(k), 1'b0);
        step(1'b1, 32'hBAD, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (overflow !== 1'b0 || obs_status() !== exp_status()) begin
            tests_failed++;
            $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
        step(1'b1, 32'hBAD, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (overflow !== 1'b1 || obs_status() !== exp_status()) begin
            tests_failed++;
            $display("FAIL ovf_set_wins: got %b expected 1", overflow);
        end
        for (int k = 0; k < 32; k++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        tests_run++;
        if (underflow !== 1'b1 || obs_status() !== exp_status()) begin
            tests_failed++;
            $display("FAIL unf_set: got %b expected 1", underflow);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (obs_status() !== RESET_STATUS) begin
            tests_failed++;
            $display("FAIL flags_clear: got %b expected %b", obs_status(), RESET_STATUS);
        end
    endtask

    task automatic test_parity();
        int hits_before;
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 32'h0F, 1'b0);
        step(1'b1, 32'hF0, 1'b0);
        hits_before = par_hits;
`ifdef FIFO_PARITY_EN
        dut.mem[0][0] = ~dut.mem[0][0];
        exp_q[0] = exp_q[0] ^ 32'h1;
`endif
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        tests_run++;
`ifdef FIFO_PARITY_EN
        if (par_hits - hits_before !== 1) begin
            tests_failed++;
            $display("FAIL parity_err: got %0d pulses expected 1", par_hits - hits_before);
        end
`else
        if (par_hits !== 0) begin
            tests_failed++;
            $display("FAIL parity_tied: got %0d pulses expected 0", par_hits);
        end
`endif
    endtask

    task automatic test_wrap5();
        logic [7:0] q5[$];
        logic [7:0] exp_d;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push5 = 1'b1; datain5 = 8'h30 + 8'(i); q5.push_back(datain5);
            @(posedge clk); #1; push5 = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            push5 = 1'b1; pull5 = 1'b1; datain5 = 8'h40 + 8'(i);
            #1;
            exp_d = q5.pop_front();
            q5.push_back(datain5);
            tests_run++;
            if (dataout5 !== exp_d) begin
                tests_failed++;
                $display("FAIL wrap5_data@%0d: got %h expected %h", i, dataout5, exp_d);
            end
            @(posedge clk); #1;
            push5 = 1'b0; pull5 = 1'b0;
            tests_run++;
            if (count5 !== 3'd3) begin
                tests_failed++;
                $display("FAIL wrap5_count@%0d: got %0d expected 3", i, count5);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pull5 = 1'b1;
            #1;
            exp_d = q5.pop_front();
            tests_run++;
            if (dataout5 !== exp_d) begin
                tests_failed++;
                $display("FAIL wrap5_drain@%0d: got %h expected %h", i, dataout5, exp_d);
            end
            @(posedge clk); #1; pull5 = 1'b0;
        end
        tests_run++;
        if (empty5 !== 1'b1 || unf5 !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap5_empty: got %b/%b expected 1/0", empty5, unf5);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) step(1'b1, 32'h400 + 32'(k), 1'b0);
        @(negedge clk);
        push = 1'b1; datain = 32'h77;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (obs_status() !== RESET_STATUS || dataout !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_async: got %b/%h expected %b/0", obs_status(), dataout, RESET_STATUS);
        end
        push = 1'b0;
        exp_q.delete(); m_count = 0; m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0);
        tests_run++;
        if (obs_status() !== RESET_STATUS || dataout !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_release: got %b/%h expected %b/0", obs_status(), dataout, RESET_STATUS);
        end
    endtask

    initial begin
        #12 rst_n = 1'b1;
        #1;
        test_reset();
        test_fill_drain();
        test_both_ops();
        test_flush();
        test_sticky();
        test_parity();
        test_wrap5();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
